// File: rtl/comparator_pkg.sv
// Shared types for the registered comparator: outcome encoding and its one-hot decode.
package comparator_pkg;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_e;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } flags_t;

  localparam int NUM_OUTCOMES = 3;

  function automatic flags_t cmp_onehot(input cmp_e c);
    flags_t f;
    f = '0;
    case (c)
      CMP_LT:  f.lt = 1'b1;
      CMP_EQ:  f.eq = 1'b1;
      CMP_GT:  f.gt = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparator_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator with one-hot Gt/Eq/Lt flags and saturating
// per-outcome counters; all outputs are taken straight from flops.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int SIGNED    = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic                 Gt,
  output logic                 Eq,
  output logic                 Lt,
  output logic [CNT_WIDTH-1:0] gt_cnt,
  output logic [CNT_WIDTH-1:0] eq_cnt,
  output logic [CNT_WIDTH-1:0] lt_cnt
);

  logic   a_gt_b;
  logic   a_lt_b;
  cmp_e   outcome;
  flags_t flags_q;
  flags_t flags_d;
  logic   out_valid_q;
  logic   out_valid_d;

  // Equality is a pure bit-pattern test; only the ordering depends on SIGNED.
  if (SIGNED != 0) begin : g_signed
    assign a_gt_b = $signed(a) > $signed(b);
    assign a_lt_b = $signed(a) < $signed(b);
  end else begin : g_unsigned
    assign a_gt_b = a > b;
    assign a_lt_b = a < b;
  end

  always_comb begin
    outcome = CMP_EQ;
    if (a_gt_b) begin
      outcome = CMP_GT;
    end else if (a_lt_b) begin
      outcome = CMP_LT;
    end
  end

  always_comb begin
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      flags_d = cmp_onehot(outcome);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Gt        = flags_q.gt;
  assign Eq        = flags_q.eq;
  assign Lt        = flags_q.lt;

  logic [CNT_WIDTH-1:0] cnt_w [NUM_OUTCOMES];

  for (genvar gi = 0; gi < NUM_OUTCOMES; gi++) begin : g_cnt
    logic inc;
    assign inc = in_valid && (outcome == cmp_e'(2'(gi)));

    sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .count(cnt_w[gi])
    );
  end

  assign lt_cnt = cnt_w[CMP_LT];
  assign eq_cnt = cnt_w[CMP_EQ];
  assign gt_cnt = cnt_w[CMP_GT];

endmodule

// File: tb/tb_comparator.sv
// Randomised and directed bench: five comparator configurations share one
// stimulus stream and are checked against an integer-arithmetic model.
module tb_comparator;

  localparam int N = 5;
  // 0: W2 unsigned, 1: W2 signed, 2: W2 unsigned 2-bit counters,
  // 3: W8 unsigned, 4: W8 signed
  localparam int WD [N] = '{2, 2, 2, 8, 8};
  localparam int SG [N] = '{0, 1, 0, 0, 1};
  localparam int CW [N] = '{8, 8, 2, 16, 16};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;

  logic        ov_o [N];
  logic [2:0]  fl_o [N];
  logic [15:0] gc_o [N];
  logic [15:0] ec_o [N];
  logic [15:0] lc_o [N];

  logic [7:0]  c0g, c0e, c0l, c1g, c1e, c1l;
  logic [1:0]  c2g, c2e, c2l;
  logic [15:0] c3g, c3e, c3l, c4g, c4e, c4l;

  always #5 clk = ~clk;

  comparator #(.WIDTH(2), .SIGNED(0), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8[1:0]), .b(b8[1:0]),
    .out_valid(ov_o[0]), .Gt(fl_o[0][2]), .Eq(fl_o[0][1]), .Lt(fl_o[0][0]),
    .gt_cnt(c0g), .eq_cnt(c0e), .lt_cnt(c0l));
  comparator #(.WIDTH(2), .SIGNED(1), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8[1:0]), .b(b8[1:0]),
    .out_valid(ov_o[1]), .Gt(fl_o[1][2]), .Eq(fl_o[1][1]), .Lt(fl_o[1][0]),
    .gt_cnt(c1g), .eq_cnt(c1e), .lt_cnt(c1l));
  comparator #(.WIDTH(2), .SIGNED(0), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8[1:0]), .b(b8[1:0]),
    .out_valid(ov_o[2]), .Gt(fl_o[2][2]), .Eq(fl_o[2][1]), .Lt(fl_o[2][0]),
    .gt_cnt(c2g), .eq_cnt(c2e), .lt_cnt(c2l));
  comparator #(.WIDTH(8), .SIGNED(0), .CNT_WIDTH(16)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov_o[3]), .Gt(fl_o[3][2]), .Eq(fl_o[3][1]), .Lt(fl_o[3][0]),
    .gt_cnt(c3g), .eq_cnt(c3e), .lt_cnt(c3l));
  comparator #(.WIDTH(8), .SIGNED(1), .CNT_WIDTH(16)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov_o[4]), .Gt(fl_o[4][2]), .Eq(fl_o[4][1]), .Lt(fl_o[4][0]),
    .gt_cnt(c4g), .eq_cnt(c4e), .lt_cnt(c4l));

  assign gc_o[0] = {8'd0, c0g};  assign ec_o[0] = {8'd0, c0e};  assign lc_o[0] = {8'd0, c0l};
  assign gc_o[1] = {8'd0, c1g};  assign ec_o[1] = {8'd0, c1e};  assign lc_o[1] = {8'd0, c1l};
  assign gc_o[2] = {14'd0, c2g}; assign ec_o[2] = {14'd0, c2e}; assign lc_o[2] = {14'd0, c2l};
  assign gc_o[3] = c3g;          assign ec_o[3] = c3e;          assign lc_o[3] = c3l;
  assign gc_o[4] = c4g;          assign ec_o[4] = c4e;          assign lc_o[4] = c4l;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: raw outcome tallies and the last one-hot result per instance.
  int          m_gt [N], m_eq [N], m_lt [N];
  logic [2:0]  m_fl [N];
  logic        m_ov;
  int          accepted;

  function automatic int as_int(input int i, input int unsigned x);
    int m;
    m = int'(x & ((32'd1 << WD[i]) - 1));
    if (SG[i] != 0 && m >= (1 << (WD[i] - 1))) m = m - (1 << WD[i]);
    return m;
  endfunction

  function automatic int sat(input int i, input int c);
    int lim;
    lim = (1 << CW[i]) - 1;
    return (c > lim) ? lim : c;
  endfunction

  task automatic step(input logic r, input logic v, input int unsigned va, input int unsigned vb);
    int x, y;
    rst = r; in_valid = v; a8 = va[7:0]; b8 = vb[7:0];
    @(posedge clk);
    if (r) begin
      m_ov = 1'b0;
      accepted = 0;
      for (int i = 0; i < N; i++) begin
        m_gt[i] = 0; m_eq[i] = 0; m_lt[i] = 0; m_fl[i] = 3'b000;
      end
    end else begin
      m_ov = v;
      if (v) begin
        accepted++;
        for (int i = 0; i < N; i++) begin
          x = as_int(i, va);
          y = as_int(i, vb);
          if (x > y)       begin m_fl[i] = 3'b100; m_gt[i]++; end
          else if (x == y) begin m_fl[i] = 3'b010; m_eq[i]++; end
          else             begin m_fl[i] = 3'b001; m_lt[i]++; end
        end
      end
    end
    // Disturb the inputs before sampling so any input-to-output path shows up.
    #1;
    in_valid = ~v; a8 = ~va[7:0]; b8 = ~vb[7:0]; rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d.out_valid", i), ov_o[i], m_ov);
      check($sformatf("u%0d.flags", i), fl_o[i], m_fl[i]);
      check($sformatf("u%0d.gt_cnt", i), gc_o[i], sat(i, m_gt[i]));
      check($sformatf("u%0d.eq_cnt", i), ec_o[i], sat(i, m_eq[i]));
      check($sformatf("u%0d.lt_cnt", i), lc_o[i], sat(i, m_lt[i]));
      if (m_gt[i] + m_eq[i] + m_lt[i] > 0)
        check($sformatf("u%0d.onehot", i), $countones(fl_o[i]), 1);
    end
  endtask

  int unsigned seq_a [7] = '{0, 1, 1, 1, 2, 3, 3};
  int unsigned seq_b [7] = '{0, 0, 1, 2, 2, 2, 3};
  logic [2:0]  seq_f [7] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010};

  function automatic int unsigned pick8();
    case ($urandom_range(0, 7))
      0:       return 32'h00;
      1:       return 32'h7f;
      2:       return 32'h80;
      3:       return 32'hff;
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  initial begin
    int unsigned ra, rb;
    logic        rv, rr;

    step(1'b1, 1'b0, 0, 0);
    check("reset.out_valid", ov_o[0], 0);
    check("reset.flags", fl_o[0], 0);

    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, seq_a[k], seq_b[k]);
      check($sformatf("seq%0d.flags", k), fl_o[0], seq_f[k]);
      $display("seq %0d: a=%0d b=%0d flags=%b", k, seq_a[k], seq_b[k], fl_o[0]);
    end
    check("seq.gt_cnt", gc_o[0], 2);
    check("seq.eq_cnt", ec_o[0], 4);
    check("seq.lt_cnt", lc_o[0], 1);

    step(1'b1, 1'b1, 3, 0);
    check("rst_valid.flags", fl_o[0], 0);
    check("rst_valid.out_valid", ov_o[0], 0);
    check("rst_valid.gt_cnt", gc_o[0], 0);
    step(1'b0, 1'b1, 0, 0);
    check("post_rst.flags", fl_o[0], 3'b010);

    step(1'b0, 1'b1, 2, 1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
      check($sformatf("hold%0d.gt", k), fl_o[0][2], 1);
      check($sformatf("hold%0d.out_valid", k), ov_o[0], 0);
      check($sformatf("hold%0d.gt_cnt", k), gc_o[0], 1);
    end

    step(1'b0, 1'b1, 3, 1);
    check("signed_m1_p1.lt", fl_o[1], 3'b001);
    check("unsigned_3_1.gt", fl_o[0], 3'b100);
    step(1'b0, 1'b1, 2, 3);
    check("signed_m2_m1.lt", fl_o[1], 3'b001);
    check("unsigned_2_3.lt", fl_o[0], 3'b001);

    step(1'b1, 1'b0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, 1, 1);
      check($sformatf("sat%0d.eq_cnt", k), ec_o[2], (k > 3) ? 3 : k);
      check($sformatf("sat%0d.gt_cnt", k), gc_o[2], 0);
      check($sformatf("sat%0d.lt_cnt", k), lc_o[2], 0);
    end

    step(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 1000; k++) begin
      ra = pick8();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick8();
      rv = ($urandom_range(0, 9) != 0);
      rr = ($urandom_range(0, 199) == 0);
      step(rr, rv, ra, rb);
    end
    for (int i = 3; i < N; i++)
      check($sformatf("u%0d.total", i), gc_o[i] + ec_o[i] + lc_o[i], accepted);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule
